stb_sampler: RTL and testbench
==============================

// Module: stb_sampler
// PURPOSE
//  Downstream consumer of the measure-unit strobe generator. On each rising edge of the
//  strobe, samples the comparator output and accumulates hit/total counts over a
//  programmed number of strobes. Reports the result via a start/done handshake.
//  The result feeds the calibration CPU as a hit-probability estimate.
// PARAMETERS
//  CNT_WIDTH      16       width of sample-count request and result counters
//  SYNC_STAGES    2        flip-flop stages of the cmp_i synchroniser (>=2)
//  TIMEOUT_WIDTH  24       width of the strobe-gap watchdog counter
//  TIMEOUT_CYCLES 1000000  clk cycles without a strobe edge before timeout (< 2**TIMEOUT_WIDTH)
// PORTS
//  clk_i        in   1          system clock
//  arst_i       in   1          asynchronous reset, active high
//  start_i      in   1          1-cycle request to start a run; honoured only when rdy_o=1
//  abort_i      in   1          return to IDLE at once; no done_o pulse
//  n_samples_i  in   CNT_WIDTH  strobes to sample; captured on an accepted start_i
//  stb_i        in   1          strobe from the generator; synchronous to clk_i, no sync needed
//  cmp_i        in   1          comparator output; asynchronous, passed through sync_ff
//  rdy_o        out  1          1 in IDLE
//  busy_o       out  1          1 in ARM or COUNT
//  done_o       out  1          1-cycle pulse: results valid from this cycle on
//  hit_cnt_o    out  CNT_WIDTH  number of strobes that sampled cmp=1
//  total_cnt_o  out  CNT_WIDTH  number of strobes sampled
//  timeout_o    out  1          last run ended by the watchdog
// BEHAVIOUR
//  - Reset (async): state=IDLE; all counters and outputs 0; rdy_o=1.
//  - cmp_s = cmp_i after SYNC_STAGES flops.
//  - stb_rise = stb_i & ~stb_q, where stb_q is stb_i registered by one cycle.
//  - Each sample takes cmp_s in the stb_rise cycle.
//  - IDLE:
//    - start_i with n_samples_i==0 -> DONE; counts are 0.
//    - start_i with n_samples_i!=0 -> capture n_req; clear hit, total and timeout_o; -> ARM.
//  - ARM: wait for stb_i==0; then -> COUNT. A strobe already high at start is never counted.
//  - COUNT, on stb_rise:
//    - total += 1; hit += cmp_s.
//    - If total+1 == n_req (the last sample), -> DONE.
//  - DONE (1 cycle): done_o=1; -> IDLE.
//  - Result registers hold until the next accepted start_i.
//  - start_i outside IDLE is ignored.
//  - abort_i (ARM or COUNT) -> IDLE:
//    - counters keep partial values; done_o not asserted.
//    - abort_i wins over a simultaneous stb_rise or timeout.
//  - Invariant hit <= total <= n_req <= 2**CNT_WIDTH-1, so no overflow or wrap.
//  - Latency: done_o rises 1 cycle after the registered stb_rise of the last sample;
//    hit_cnt_o and total_cnt_o are already final in the done_o cycle.
//  - arst_i mid-run: immediate IDLE, outputs 0, no done_o.
// CONFIGURATION
//  - STB_SAMPLER_TIMEOUT_EN defined:
//    - gap counter clears on entering ARM and on each stb_rise; increments in ARM/COUNT.
//    - On reaching TIMEOUT_CYCLES: timeout_o=1; -> DONE (done_o pulses);
//      hit_cnt_o/total_cnt_o hold the partial counts.
//    - A stb_rise in the same cycle is counted and takes precedence (no timeout).
//  - STB_SAMPLER_TIMEOUT_EN undefined:
//    - no gap counter; timeout_o tied 0.
//    - a missing strobe stalls in ARM/COUNT until abort_i or arst_i.
// TESTING
//  - n=8; cmp_i=1 on strobes 1,3,4 only -> done_o once after 8th edge; hit=3, total=8.
//  - n=0 start -> done_o on 2nd cycle after start; hit=0, total=0; rdy_o back 1 cycle later.
//  - stb_i high at start, n=2 -> that strobe ignored; done after 2 further rising edges.
//  - start_i pulsed during COUNT with n=5 -> ignored; run ends after original n; results
//    match the original n.
//  - abort_i after 3 of 10 strobes -> IDLE; no done_o; total=3; a new start clears counts.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=100, n=10, strobes stop after 4 -> done_o ~100 cycles after
//    the 4th edge; timeout_o=1; total=4.

Source files
------------

// File: rtl/stb_sampler.sv
// stb_sampler: samples a comparator on each rising edge of the strobe and counts
// hits and total samples over a programmed number of strobes. A start/done
// handshake hands the result to the calibration CPU.
// Optional strobe-gap watchdog: define STB_SAMPLER_TIMEOUT_EN. Without it there is
// no gap counter, timeout_o stays 0, and a missing strobe stalls the run until
// abort_i or arst_i.
module stb_sampler #(
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_WIDTH  = 24,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [CNT_WIDTH-1:0] n_samples_i,
   input  logic                 stb_i,
   input  logic                 cmp_i,
   output logic                 rdy_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] hit_cnt_o,
   output logic [CNT_WIDTH-1:0] total_cnt_o,
   output logic                 timeout_o
);

   typedef enum logic [1:0] {StIdle, StArm, StCount, StDone} state_e;

   // Parameter legality, caught at elaboration
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("stb_sampler: SYNC_STAGES must be at least 2");
   end
   if (64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
      $error("stb_sampler: TIMEOUT_CYCLES does not fit in TIMEOUT_WIDTH");
   end

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   stb_q;
   logic [CNT_WIDTH-1:0]   n_req_q, n_req_d;
   logic [CNT_WIDTH-1:0]   hit_q, hit_d;
   logic [CNT_WIDTH-1:0]   total_q, total_d;
   logic [CNT_WIDTH-1:0]   total_inc;
   logic                   timeout_q, timeout_d;
   logic                   cmp_s;
   logic                   stb_rise;
   logic                   gap_clr;
   logic                   gap_expired;

   assign cmp_s     = sync_q[SYNC_STAGES-1];
   assign stb_rise  = stb_i & ~stb_q;
   assign total_inc = total_q + CNT_WIDTH'(1);

   // Shift the asynchronous comparator through the synchroniser chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], cmp_i};
   end

`ifdef STB_SAMPLER_TIMEOUT_EN
   localparam logic [TIMEOUT_WIDTH-1:0] GapLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] gap_q, gap_d;

   // Gap counter: cleared on entering ARM and on every strobe edge, runs in ARM/COUNT
   always_comb begin
      gap_d = gap_q;
      if (gap_clr || stb_rise) begin
         gap_d = '0;
      end else if (state_q == StArm || state_q == StCount) begin
         gap_d = gap_q + TIMEOUT_WIDTH'(1);
      end
   end

   // Expires when this cycle would be the TIMEOUT_CYCLES-th without a strobe edge
   assign gap_expired = (gap_q == GapLast) && !stb_rise;

   // Watchdog counter register
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`else
   assign gap_expired = 1'b0;
`endif

   // Next-state and result-counter logic; abort beats a strobe edge, which beats the watchdog
   always_comb begin
      state_d   = state_q;
      n_req_d   = n_req_q;
      hit_d     = hit_q;
      total_d   = total_q;
      timeout_d = timeout_q;
      gap_clr   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               hit_d     = '0;
               total_d   = '0;
               timeout_d = 1'b0;
               if (n_samples_i == '0) begin
                  state_d = StDone;
               end else begin
                  n_req_d = n_samples_i;
                  gap_clr = 1'b1;
                  state_d = StArm;
               end
            end
         end
         StArm: begin
            // A strobe already high at start must fall before it can be counted
            if (abort_i) begin
               state_d = StIdle;
            end else if (!stb_i) begin
               state_d = StCount;
            end else if (gap_expired) begin
               timeout_d = 1'b1;
               state_d   = StDone;
            end
         end
         StCount: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (stb_rise) begin
               total_d = total_inc;
               hit_d   = hit_q + CNT_WIDTH'(cmp_s);
               if (total_inc == n_req_q) begin
                  state_d = StDone;
               end
            end else if (gap_expired) begin
               timeout_d = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, strobe history, synchroniser and result registers
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         stb_q     <= 1'b0;
         n_req_q   <= '0;
         hit_q     <= '0;
         total_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         stb_q     <= stb_i;
         n_req_q   <= n_req_d;
         hit_q     <= hit_d;
         total_q   <= total_d;
         timeout_q <= timeout_d;
      end
   end

   // Status and result outputs decoded from registered state
   always_comb begin
      rdy_o       = (state_q == StIdle);
      busy_o      = (state_q == StArm) || (state_q == StCount);
      done_o      = (state_q == StDone);
      hit_cnt_o   = hit_q;
      total_cnt_o = total_q;
      timeout_o   = timeout_q;
   end

endmodule

// File: tb/tb_stb_sampler.sv
// Directed bench for stb_sampler; timeout scenario runs when STB_SAMPLER_TIMEOUT_EN is defined.
module tb_stb_sampler;

   localparam int unsigned CW = 16;
`ifdef STB_SAMPLER_TIMEOUT_EN
   localparam int unsigned TO = 100;
`else
   localparam int unsigned TO = 1000000;
`endif

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          start_i;
   logic          abort_i;
   logic [CW-1:0] n_samples_i;
   logic          stb_i;
   logic          cmp_i;
   logic          rdy_o;
   logic          busy_o;
   logic          done_o;
   logic [CW-1:0] hit_cnt_o;
   logic [CW-1:0] total_cnt_o;
   logic          timeout_o;

   int n_cmp    = 0;
   int n_err    = 0;
   int done_cnt = 0;
   int d0;

   always #5 clk_i = ~clk_i;

   // Count every done_o pulse, sampled away from the active edge
   always @(negedge clk_i) begin
      if (done_o) done_cnt++;
   end

   stb_sampler #(
      .CNT_WIDTH     (CW),
      .SYNC_STAGES   (2),
      .TIMEOUT_WIDTH (24),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .n_samples_i(n_samples_i),
      .stb_i      (stb_i),
      .cmp_i      (cmp_i),
      .rdy_o      (rdy_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .hit_cnt_o  (hit_cnt_o),
      .total_cnt_o(total_cnt_o),
      .timeout_o  (timeout_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic do_start(input logic [CW-1:0] n);
      n_samples_i = n;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   // Settle cmp_i through the synchroniser, then one strobe rise; returns just after that edge
   task automatic strobe(input logic c);
      cmp_i = c;
      repeat (3) tick();
      stb_i = 1'b1;
      tick();
      stb_i = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      int         waited;
      arst_i      = 1'b1;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      n_samples_i = '0;
      stb_i       = 1'b0;
      cmp_i       = 1'b0;
      repeat (2) tick();
      check("rst_rdy", 32'(rdy_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_hit", 32'(hit_cnt_o), 0);
      check("rst_total", 32'(total_cnt_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      arst_i = 1'b0;
      tick();

      // n=8, cmp high on strobes 1,3,4
      d0  = done_cnt;
      pat = 8'b0000_1101;
      do_start(8);
      check("t1_busy", 32'(busy_o), 1);
      for (int i = 0; i < 8; i++) begin
         strobe(pat[i]);
         if (i == 6) begin
            check("t1_done_early", 32'(done_o), 0);
            check("t1_total7", 32'(total_cnt_o), 7);
         end
      end
      check("t1_done", 32'(done_o), 1);
      check("t1_hit", 32'(hit_cnt_o), 3);
      check("t1_total", 32'(total_cnt_o), 8);
      check("t1_timeout", 32'(timeout_o), 0);
      tick();
      check("t1_rdy", 32'(rdy_o), 1);
      check("t1_done_off", 32'(done_o), 0);
      check("t1_pulses", 32'(done_cnt - d0), 1);

      // n=0 finishes at once with cleared counts
      d0 = done_cnt;
      do_start(0);
      check("t2_done", 32'(done_o), 1);
      check("t2_rdy_low", 32'(rdy_o), 0);
      check("t2_hit", 32'(hit_cnt_o), 0);
      check("t2_total", 32'(total_cnt_o), 0);
      tick();
      check("t2_rdy", 32'(rdy_o), 1);
      check("t2_pulses", 32'(done_cnt - d0), 1);

      // strobe already high at start is ignored
      cmp_i = 1'b1;
      stb_i = 1'b1;
      repeat (3) tick();
      do_start(2);
      tick();
      check("t3_arm_busy", 32'(busy_o), 1);
      stb_i = 1'b0;
      tick();
      strobe(1'b1);
      check("t3_done_early", 32'(done_o), 0);
      check("t3_total1", 32'(total_cnt_o), 1);
      strobe(1'b0);
      check("t3_done", 32'(done_o), 1);
      check("t3_hit", 32'(hit_cnt_o), 1);
      check("t3_total", 32'(total_cnt_o), 2);
      tick();

      // start during COUNT is ignored
      d0 = done_cnt;
      do_start(5);
      strobe(1'b1);
      n_samples_i = 2;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
      for (int i = 0; i < 3; i++) strobe(1'b1);
      check("t4_done_early", 32'(done_o), 0);
      check("t4_total4", 32'(total_cnt_o), 4);
      strobe(1'b1);
      check("t4_done", 32'(done_o), 1);
      check("t4_hit", 32'(hit_cnt_o), 5);
      check("t4_total", 32'(total_cnt_o), 5);
      tick();
      check("t4_pulses", 32'(done_cnt - d0), 1);

      // abort after 3 of 10 keeps partial counts, no done
      d0 = done_cnt;
      do_start(10);
      strobe(1'b1);
      strobe(1'b0);
      strobe(1'b1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("t5_rdy", 32'(rdy_o), 1);
      check("t5_busy", 32'(busy_o), 0);
      check("t5_total", 32'(total_cnt_o), 3);
      check("t5_hit", 32'(hit_cnt_o), 2);
      tick();
      check("t5_pulses", 32'(done_cnt - d0), 0);
      do_start(1);
      check("t5_clr_total", 32'(total_cnt_o), 0);
      check("t5_clr_hit", 32'(hit_cnt_o), 0);
      strobe(1'b1);
      check("t5_done", 32'(done_o), 1);
      check("t5_total1", 32'(total_cnt_o), 1);
      tick();

      // asynchronous reset mid-run
      d0 = done_cnt;
      do_start(4);
      strobe(1'b1);
      #2 arst_i = 1'b1;
      #1;
      check("t6_rdy", 32'(rdy_o), 1);
      check("t6_busy", 32'(busy_o), 0);
      check("t6_total", 32'(total_cnt_o), 0);
      check("t6_hit", 32'(hit_cnt_o), 0);
      tick();
      arst_i = 1'b0;
      repeat (2) tick();
      check("t6_pulses", 32'(done_cnt - d0), 0);

`ifdef STB_SAMPLER_TIMEOUT_EN
      // strobes stop after 4 of 10; watchdog ends the run 100 cycles after the 4th edge
      do_start(10);
      for (int i = 0; i < 4; i++) strobe(1'b1);
      waited = 0;
      while (!done_o && waited < 300) begin
         tick();
         waited++;
      end
      check("t7_wait", 32'(waited), 100);
      check("t7_done", 32'(done_o), 1);
      check("t7_timeout", 32'(timeout_o), 1);
      check("t7_total", 32'(total_cnt_o), 4);
      check("t7_hit", 32'(hit_cnt_o), 4);
      tick();
      do_start(1);
      check("t7_clr_timeout", 32'(timeout_o), 0);
      strobe(1'b0);
      tick();
`else
      waited = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
